// File: rtl/mem_access_stage.sv
// Memory stage of the 16-bit pipeline: request/done handshake with data memory, global stall,
// misalignment flag and dump forwarding. Optional watchdog enabled by defining MEM_TIMEOUT_EN.
module mem_access_stage #(
  parameter int ADDR_W         = 16,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [15:0]       EXMem_alu_out,
  input  logic [15:0]       EXMem_write_data,
  input  logic              EXMem_DMemEn,
  input  logic              EXMem_DMemWrite,
  input  logic              EXMem_DMemDump,
  input  logic [15:0]       mem_rdata,
  input  logic              mem_done,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       mem_wdata,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [15:0]       Mem_read_data,
  output logic              Mem_stall,
  output logic              Mem_err,
  output logic              Mem_DMemDump
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t            r_state;
  state_t            w_next_state;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [15:0]       r_mem_wdata;
  logic              r_mem_rd;
  logic              r_mem_wr;
  logic [15:0]       r_hold;
  logic              r_timeout_err;
  logic              w_misaligned;
  logic              w_start;
  logic              w_done;
  logic              w_timeout;

  assign w_misaligned = EXMem_DMemEn && EXMem_alu_out[0];
  assign w_start      = (r_state == IDLE) && EXMem_DMemEn && !EXMem_alu_out[0];
  assign w_done       = (r_state == BUSY) && mem_done;

`ifdef MEM_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] r_count;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_count <= '0;
    end else if (w_start) begin
      r_count <= '0;
    end else if (r_state == BUSY) begin
      r_count <= r_count + CW'(1);
    end
  end

  // The counter reads TIMEOUT_CYCLES-1 during the last permitted BUSY cycle; a done there still wins.
  assign w_timeout = (r_state == BUSY) && !mem_done && (r_count == CW'(TIMEOUT_CYCLES - 1));
`else
  assign w_timeout = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state  = r_state;
    Mem_stall     = 1'b0;
    Mem_err       = 1'b0;
    Mem_DMemDump  = 1'b0;
    Mem_read_data = r_hold;
    case (r_state)
      IDLE: begin
        if (w_start) begin
          w_next_state = BUSY;
          Mem_stall    = 1'b1;
        end else begin
          Mem_DMemDump = EXMem_DMemDump;
        end
        if (w_misaligned) begin
          Mem_err       = 1'b1;
          Mem_read_data = '0;
        end
      end
      BUSY: begin
        Mem_stall = 1'b1;
        if (w_done || w_timeout) begin
          w_next_state = DONE;
        end
      end
      DONE: begin
        Mem_err      = r_timeout_err;
        w_next_state = IDLE;
      end
      default: w_next_state = IDLE;
    endcase
    // Combinational outputs are forced quiet while reset is held, even if an access is presented.
    if (!rst) begin
      Mem_stall     = 1'b0;
      Mem_err       = 1'b0;
      Mem_DMemDump  = 1'b0;
      Mem_read_data = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_mem_addr    <= '0;
      r_mem_wdata   <= '0;
      r_mem_rd      <= 1'b0;
      r_mem_wr      <= 1'b0;
      r_hold        <= '0;
      r_timeout_err <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_start) begin
            r_mem_addr  <= ADDR_W'(EXMem_alu_out);
            r_mem_wdata <= EXMem_write_data;
            r_mem_rd    <= !EXMem_DMemWrite;
            r_mem_wr    <= EXMem_DMemWrite;
          end
        end
        BUSY: begin
          if (w_done) begin
            r_mem_rd <= 1'b0;
            r_mem_wr <= 1'b0;
            if (r_mem_rd) begin
              r_hold <= mem_rdata;
            end
          end else if (w_timeout) begin
            r_mem_rd      <= 1'b0;
            r_mem_wr      <= 1'b0;
            r_hold        <= '0;
            r_timeout_err <= 1'b1;
          end
        end
        DONE: begin
          r_timeout_err <= 1'b0;
        end
        default: begin
          r_mem_rd <= 1'b0;
          r_mem_wr <= 1'b0;
        end
      endcase
    end
  end

  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign mem_rd    = r_mem_rd;
  assign mem_wr    = r_mem_wr;

endmodule

// File: tb/tb_mem_access_stage.sv
// Scoreboard bench for mem_access_stage: directed accesses push expected completions,
// a negedge monitor pops and compares them when the stall drops.
module tb_mem_access_stage;

  logic        clk;
  logic        rst;
  logic [15:0] EXMem_alu_out;
  logic [15:0] EXMem_write_data;
  logic        EXMem_DMemEn;
  logic        EXMem_DMemWrite;
  logic        EXMem_DMemDump;
  logic [15:0] mem_rdata;
  logic        mem_done;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_rd;
  logic        mem_wr;
  logic [15:0] Mem_read_data;
  logic        Mem_stall;
  logic        Mem_err;
  logic        Mem_DMemDump;

  typedef struct {
    logic [15:0] data;
    logic        err;
  } exp_t;

  exp_t        expQ[$];
  logic [15:0] expHold;
  int          checks;
  int          errors;
  int          rdWindows;
  int          wrWindows;
  logic        prevStall;
  logic        prevRd;
  logic        prevWr;

  mem_access_stage #(
    .ADDR_W(16),
    .TIMEOUT_CYCLES(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .EXMem_alu_out(EXMem_alu_out),
    .EXMem_write_data(EXMem_write_data),
    .EXMem_DMemEn(EXMem_DMemEn),
    .EXMem_DMemWrite(EXMem_DMemWrite),
    .EXMem_DMemDump(EXMem_DMemDump),
    .mem_rdata(mem_rdata),
    .mem_done(mem_done),
    .mem_addr(mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rd(mem_rd),
    .mem_wr(mem_wr),
    .Mem_read_data(Mem_read_data),
    .Mem_stall(Mem_stall),
    .Mem_err(Mem_err),
    .Mem_DMemDump(Mem_DMemDump)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Monitor: a falling stall marks the DONE cycle of an access; compare it against the scoreboard.
  always @(negedge clk) begin
    if (!rst) begin
      prevStall = 1'b0;
    end else begin
      if (mem_rd && !prevRd) rdWindows++;
      if (mem_wr && !prevWr) wrWindows++;
      if (prevStall && !Mem_stall) begin
        if (expQ.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpectedDone: got a completion, expected none at %0t", $time);
        end else begin
          exp_t e;
          e = expQ.pop_front();
          checkOutput("doneReadData", Mem_read_data, e.data);
          checkOutput("doneErr", Mem_err, e.err);
        end
      end
      prevStall = Mem_stall;
    end
    prevRd = mem_rd;
    prevWr = mem_wr;
  end

  // Issues one aligned access starting just after a posedge; memory answers on request cycle 'latency'.
  task automatic applyStimulus(input logic [15:0] addr, input logic [15:0] data, input logic write,
                               input int latency, input logic noDone, input logic [15:0] rdata,
                               input string name);
    exp_t e;
    EXMem_DMemEn     = 1'b1;
    EXMem_alu_out    = addr;
    EXMem_write_data = data;
    EXMem_DMemWrite  = write;
    if (noDone) e.data = 16'h0000;
    else if (write) e.data = expHold;
    else e.data = rdata;
    e.err = noDone;
    expHold = e.data;
    expQ.push_back(e);
    @(negedge clk);
    checkOutput({name, "_stallN"}, Mem_stall, 1);
    checkOutput({name, "_dumpN"}, Mem_DMemDump, 0);
    @(posedge clk); #1;
    for (int i = 1; i <= latency; i++) begin
      mem_done  = !noDone && (i == latency);
      mem_rdata = (i == latency) ? rdata : 16'hDEAD;
      @(negedge clk);
      checkOutput({name, "_stallBusy"}, Mem_stall, 1);
      checkOutput({name, "_reqLevel"}, {mem_rd, mem_wr}, write ? 2'b01 : 2'b10);
      checkOutput({name, "_addr"}, mem_addr, addr);
      checkOutput({name, "_wdata"}, mem_wdata, data);
      @(posedge clk); #1;
    end
    mem_done  = 1'b0;
    mem_rdata = 16'h0000;
    @(negedge clk);
    checkOutput({name, "_stallDone"}, Mem_stall, 0);
    checkOutput({name, "_reqDrop"}, {mem_rd, mem_wr}, 2'b00);
    @(posedge clk); #1;
    EXMem_DMemEn = 1'b0;
  endtask

  initial begin
    int rdBase;
    int wrBase;
    checks = 0; errors = 0; rdWindows = 0; wrWindows = 0;
    prevStall = 1'b0; prevRd = 1'b0; prevWr = 1'b0;
    expHold = 16'h0000;
    rst = 1'b0;
    EXMem_alu_out = 16'h0000; EXMem_write_data = 16'h0000;
    EXMem_DMemEn = 1'b0; EXMem_DMemWrite = 1'b0; EXMem_DMemDump = 1'b0;
    mem_rdata = 16'h0000; mem_done = 1'b0;

    // Reset state, then a reset asserted in the middle of a load request.
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rstOutputs", {mem_rd, mem_wr, Mem_stall, Mem_err, Mem_DMemDump}, 5'b0);
    checkOutput("rstAddrData", {mem_addr, mem_wdata, Mem_read_data}, 48'h0);
    rst = 1'b1;
    @(posedge clk); #1;
    EXMem_DMemEn = 1'b1; EXMem_alu_out = 16'h0020; EXMem_DMemWrite = 1'b0;
    @(posedge clk); #1;
    checkOutput("rstPreRd", mem_rd, 1);
    #2 rst = 1'b0;
    #1;
    checkOutput("rstMidRd", mem_rd, 0);
    checkOutput("rstMidAddr", mem_addr, 16'h0000);
    checkOutput("rstMidOutputs", {Mem_stall, Mem_err, Mem_DMemDump, Mem_read_data}, 19'h0);
    EXMem_DMemEn = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    EXMem_DMemDump = 1'b1;
    #1;
    checkOutput("rstIdleDump", Mem_DMemDump, 1);
    checkOutput("rstIdleRd", mem_rd, 0);
    EXMem_DMemDump = 1'b0;
    @(posedge clk); #1;

    rdBase = rdWindows; wrBase = wrWindows;
    applyStimulus(16'h0010, 16'h0000, 1'b0, 1, 1'b0, 16'hBEEF, "load1");
    checkOutput("load1RdWindows", rdWindows - rdBase, 1);

    wrBase = wrWindows;
    applyStimulus(16'h0A02, 16'h1234, 1'b1, 5, 1'b0, 16'h5555, "store5");
    checkOutput("store5WrWindows", wrWindows - wrBase, 1);

    // Misaligned load: error the same cycle, no request, no stall.
    rdBase = rdWindows;
    EXMem_DMemEn = 1'b1; EXMem_alu_out = 16'h0003; EXMem_DMemWrite = 1'b0;
    @(negedge clk);
    checkOutput("misErr", Mem_err, 1);
    checkOutput("misStall", Mem_stall, 0);
    checkOutput("misReadData", Mem_read_data, 16'h0000);
    @(posedge clk); #1;
    EXMem_DMemEn = 1'b0;
    @(negedge clk);
    checkOutput("misRdNever", mem_rd, 0);
    checkOutput("misErrClears", Mem_err, 0);
    checkOutput("misHoldKept", Mem_read_data, expHold);
    checkOutput("misRdWindows", rdWindows - rdBase, 0);
    @(posedge clk); #1;

    // A stray done while idle must not disturb anything.
    mem_done = 1'b1; mem_rdata = 16'h7777;
    @(negedge clk);
    checkOutput("strayDoneStall", Mem_stall, 0);
    @(posedge clk); #1;
    mem_done = 1'b0; mem_rdata = 16'h0000;
    @(negedge clk);
    checkOutput("strayDoneHold", Mem_read_data, expHold);
    checkOutput("strayDoneReq", {mem_rd, mem_wr}, 2'b00);
    @(posedge clk); #1;

    rdBase = rdWindows;
    applyStimulus(16'h0002, 16'h0000, 1'b0, 2, 1'b0, 16'h1111, "b2bFirst");
    applyStimulus(16'h0004, 16'h0000, 1'b0, 1, 1'b0, 16'h2222, "b2bSecond");
    @(negedge clk);
    checkOutput("b2bRdWindows", rdWindows - rdBase, 2);
    checkOutput("b2bNoReissue", mem_rd, 0);
    @(posedge clk); #1;

    // Dump arriving with an access is held back until the stage is idle again.
    EXMem_DMemDump = 1'b1;
    applyStimulus(16'h0008, 16'h0000, 1'b0, 1, 1'b0, 16'h4242, "dumpLoad");
    @(negedge clk);
    checkOutput("dumpAfterAccess", Mem_DMemDump, 1);
    @(posedge clk); #1;
    EXMem_DMemDump = 1'b0;

`ifdef MEM_TIMEOUT_EN
    applyStimulus(16'h0006, 16'h0000, 1'b0, 4, 1'b1, 16'h0000, "timeout");
    @(negedge clk);
    checkOutput("timeoutIdleErr", Mem_err, 0);
    checkOutput("timeoutIdleReq", {mem_rd, mem_wr}, 2'b00);
    @(posedge clk); #1;
`endif

    repeat (2) @(posedge clk);
    #1;
    checkOutput("scoreboardDrained", expQ.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- Memory stage of the 5-stage 16-bit pipeline. Sits between the EX/Mem pipeline register and the Mem/WB pipeline register.
- Takes the address and store data from EX/Mem and runs a multi-cycle request/done handshake with the data memory.
- Drives the load data and the stage's global stall, which freezes all upstream pipeline registers and the Mem/WB register while an access is outstanding.
- Flags misaligned accesses and passes the dump/halt request through.

Parameters:
- ADDR_W, 16, width of the data address and of mem_addr.
- TIMEOUT_CYCLES, 64, watchdog limit in cycles. Used only when MEM_TIMEOUT_EN is defined.

Ports:
- clk  input  1  pipeline clock
- rst  input  1  reset; asynchronous, active-low (0 = reset)
- EXMem_alu_out  input  16  effective address
- EXMem_write_data  input  16  store data
- EXMem_DMemEn  input  1  memory op present this cycle
- EXMem_DMemWrite  input  1  1 = store, 0 = load (valid only with DMemEn)
- EXMem_DMemDump  input  1  halt/dump request
- mem_rdata  input  16  memory read data, valid when mem_done=1
- mem_done  input  1  memory completion strobe, one cycle
- mem_addr  output  ADDR_W  address to memory
- mem_wdata  output  16  store data to memory
- mem_rd  output  1  read request level
- mem_wr  output  1  write request level
- Mem_read_data  output  16  load result to Mem/WB (feeds EXMem_read_data of Mem/WB)
- Mem_stall  output  1  1 = freeze the pipeline (drives en=0 of all pipeline registers)
- Mem_err  output  1  misaligned access or timeout
- Mem_DMemDump  output  1  dump request forwarded to memory when the stage is idle

Behaviour:
- Reset (rst=0, async):
  - state=IDLE.
  - mem_rd=mem_wr=0, mem_addr=0, mem_wdata=0.
  - Mem_read_data=0, Mem_stall=0, Mem_err=0, Mem_DMemDump=0.
  - Reset mid-access abandons the request; memory sees the request drop immediately.
- Misaligned access:
  - Defined as EXMem_DMemEn=1 with EXMem_alu_out[0]=1.
  - No request is issued; Mem_err=1 combinationally that cycle; Mem_stall=0; Mem_read_data=0.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - Aligned EXMem_DMemEn=1 sets Mem_stall=1 combinationally in the same cycle N.
  - Address and data are registered into mem_addr/mem_wdata; next state is BUSY.
  - mem_rd or mem_wr (per EXMem_DMemWrite) is registered high from cycle N+1.
- BUSY:
  - Request level, mem_addr and mem_wdata are held constant.
  - Mem_stall=1 while mem_done=0.
  - On mem_done=1:
    - For a load, mem_rdata is captured into a hold register.
    - mem_rd/mem_wr fall next cycle; next state is DONE.
    - Mem_stall stays 1 in the done cycle.
- DONE:
  - Mem_stall=0 and Mem_read_data = hold register, so the pipeline advances at this edge.
  - Next state is IDLE.
  - Minimum access latency is 3 cycles: N (IDLE), N+1 (BUSY, done returned), N+2 (DONE).
- Store data:
  - A store leaves the hold register unchanged.
  - Mem_read_data is a don't-care for stores; RTL drives the hold value.
- No double issue: the instruction still present on the EX/Mem inputs during DONE is not re-issued, because DONE always returns to IDLE and the pipeline advances in the same cycle.
- mem_done outside BUSY is ignored.
- Mem_DMemDump:
  - Equals EXMem_DMemDump when state=IDLE and no access is starting; otherwise 0.
  - If dump and an access arrive together, the access runs first and the dump is forwarded when the stage returns to IDLE.
- Outputs when not in DONE: Mem_read_data shows the last captured value.

Optional Feature:
- Macro: MEM_TIMEOUT_EN.
- Defined:
  - A counter (ceil(log2(TIMEOUT_CYCLES+1)) bits) clears on entry to BUSY and increments each BUSY cycle.
  - When it reaches TIMEOUT_CYCLES without mem_done: request drops, hold register is loaded with 0, Mem_err=1 for the DONE cycle, then IDLE.
  - mem_done in the same cycle as the timeout wins, with no error.
- Undefined: no counter; BUSY waits indefinitely for mem_done.

Test Plan:
- Reset: drive rst=0 mid-BUSY with mem_rd=1 -> mem_rd drops immediately; all outputs 0; state IDLE after release.
- Load, done after 1 cycle: addr 0x0010, mem_rdata=0xBEEF -> Mem_stall=1 for cycles N and N+1 and 0 at N+2; Mem_read_data=0xBEEF at N+2; exactly one mem_rd window.
- Store, done after 5 cycles: addr 0x0A02, data 0x1234 -> mem_wr held 5 cycles with mem_addr=0x0A02 and mem_wdata=0x1234 stable; Mem_read_data unchanged.
- Misaligned load at 0x0003 -> Mem_err=1 the same cycle; mem_rd never asserted; Mem_stall=0.
- Back-to-back loads at 0x0002 and 0x0004 -> two separate requests with one DONE cycle between them; no re-issue of the first.
- With MEM_TIMEOUT_EN and TIMEOUT_CYCLES=4, no mem_done -> request held 4 cycles, then DONE with Mem_err=1 and Mem_read_data=0, then IDLE.
